// File: rtl/channel_snapshot_fetch_if.sv
// ----------------------------------------------------------------------------
// channel_snapshot_fetch_if
// Bundles every non-clock signal of channel_snapshot_fetch.
//
// SPI side : load_cnt_ser (one-hot channel strobe), select_reg (byte index),
//            read_data (registered snapshot byte back to the SPI block).
// Channel  : ch_req / ch_sel / ch_ack / ch_data request/acknowledge handshake.
// Status   : snap_valid, cur_ch, timeout_err, onehot_err.
//
// Handshake: ch_req is a registered level held high while a fetch from channel
// ch_sel is outstanding. The channel answers with a single-cycle ch_ack pulse,
// and ch_data is valid in that same cycle. An ack seen while ch_req is low is
// ignored. ch_req falls on the cycle after the ack, on timeout, or for one
// cycle when the fetch is retargeted to a new channel.
//
// Modports: slave = the fetch block, master = its environment (SPI block and
// channels, or a testbench).
// ----------------------------------------------------------------------------
interface channel_snapshot_fetch_if #(
    parameter int N_CH  = 8,
    parameter int BYTES = 7
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]      load_cnt_ser;
    logic [2:0]           select_reg;
    logic                 ch_req;
    logic [CH_W-1:0]      ch_sel;
    logic                 ch_ack;
    logic [8*BYTES-1:0]   ch_data;
    logic [7:0]           read_data;
    logic                 snap_valid;
    logic [CH_W-1:0]      cur_ch;
    logic                 timeout_err;
    logic                 onehot_err;

    modport slave (
        input  load_cnt_ser, select_reg, ch_ack, ch_data,
        output ch_req, ch_sel, read_data, snap_valid, cur_ch,
               timeout_err, onehot_err
    );

    modport master (
        output load_cnt_ser, select_reg, ch_ack, ch_data,
        input  ch_req, ch_sel, read_data, snap_valid, cur_ch,
               timeout_err, onehot_err
    );
endinterface

// File: rtl/channel_snapshot_fetch.sv
// ----------------------------------------------------------------------------
// channel_snapshot_fetch
// Watches the SPI block's one-hot channel strobe. When a new channel is
// selected it fetches that channel's 56-bit counter snapshot over a req/ack
// handshake, then serves the snapshot bytes back on read_data, indexed by
// select_reg.
//
// Ports:
//   sclk      - sole clock, rising edge
//   rstn      - asynchronous active-low reset
//   bus       - channel_snapshot_fetch_if.slave (SPI side, channel handshake,
//               status flags)
//   fsm_state - debug view of the FSM: 0 = IDLE, 1 = REQ
// ----------------------------------------------------------------------------
module channel_snapshot_fetch #(
    parameter int N_CH           = 8,
    parameter int BYTES          = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          sclk,
    input  logic                          rstn,
    channel_snapshot_fetch_if.slave       bus,
    output logic                          fsm_state
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [N_CH-1:0]  LOAD_ONE = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_CH-1:0]      prev_load_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 restart_q, restart_d;
    logic                 ch_req_q, ch_req_d;
    logic [CH_W-1:0]      ch_sel_q, ch_sel_d;
    logic [8*BYTES-1:0]   snap_q, snap_d;
    logic                 snap_valid_q, snap_valid_d;
    logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 onehot_err_q, onehot_err_d;
    logic [7:0]           read_data_q, read_data_d;

    logic                 load_nonzero;
    logic                 load_onehot;
    logic                 load_multi;
    logic                 load_event;
    logic [CH_W-1:0]      load_idx;

    // ------------------------------------------------------------------
    // Load detection. x & (x-1) clears the lowest set bit, so it is zero
    // exactly when at most one bit is set.
    // ------------------------------------------------------------------
    assign load_nonzero = (bus.load_cnt_ser != '0);
    assign load_onehot  = load_nonzero &&
                          ((bus.load_cnt_ser & (bus.load_cnt_ser - LOAD_ONE)) == '0);
    assign load_multi   = load_nonzero && !load_onehot;
    assign load_event   = load_onehot && (bus.load_cnt_ser != prev_load_q);

    always_comb begin
        load_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.load_cnt_ser[i]) begin
                load_idx = CH_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and registered-output logic.
    // restart_q marks the single cycle after a retarget in which ch_req is
    // held low; the new request is raised at the end of that cycle and the
    // timeout count only starts once the request is visible again.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        restart_d     = restart_q;
        ch_req_d      = ch_req_q;
        ch_sel_d      = ch_sel_q;
        snap_d        = snap_q;
        snap_valid_d  = snap_valid_q;
        cur_ch_d      = cur_ch_q;
        timeout_err_d = timeout_err_q;
        onehot_err_d  = onehot_err_q | load_multi;

        unique case (state_q)
            IDLE: begin
                if (load_event) begin
                    state_d      = REQ;
                    ch_req_d     = 1'b1;
                    ch_sel_d     = load_idx;
                    snap_valid_d = 1'b0;
                    cnt_d        = '0;
                    restart_d    = 1'b0;
                end
            end
            REQ: begin
                if (load_event) begin
                    // Retarget: any ack in this cycle belongs to the
                    // abandoned fetch and is discarded.
                    ch_req_d     = 1'b0;
                    ch_sel_d     = load_idx;
                    snap_valid_d = 1'b0;
                    cnt_d        = '0;
                    restart_d    = 1'b1;
                end else if (restart_q) begin
                    ch_req_d  = 1'b1;
                    restart_d = 1'b0;
                end else if (bus.ch_ack) begin
                    snap_d        = bus.ch_data;
                    cur_ch_d      = ch_sel_q;
                    snap_valid_d  = 1'b1;
                    timeout_err_d = 1'b0;
                    ch_req_d      = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ch_req_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    snap_d        = '0;
                    snap_valid_d  = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read path: byte b of the snapshot is bits [8b+7:8b]; indices past the
    // last byte and an invalid snapshot both read as zero.
    // ------------------------------------------------------------------
    always_comb begin
        read_data_d = 8'h00;
        if (snap_valid_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (int'(bus.select_reg) == b) begin
                    read_data_d = snap_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            prev_load_q   <= '0;
            cnt_q         <= '0;
            restart_q     <= 1'b0;
            ch_req_q      <= 1'b0;
            ch_sel_q      <= '0;
            snap_q        <= '0;
            snap_valid_q  <= 1'b0;
            cur_ch_q      <= '0;
            timeout_err_q <= 1'b0;
            onehot_err_q  <= 1'b0;
            read_data_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            prev_load_q   <= bus.load_cnt_ser;
            cnt_q         <= cnt_d;
            restart_q     <= restart_d;
            ch_req_q      <= ch_req_d;
            ch_sel_q      <= ch_sel_d;
            snap_q        <= snap_d;
            snap_valid_q  <= snap_valid_d;
            cur_ch_q      <= cur_ch_d;
            timeout_err_q <= timeout_err_d;
            onehot_err_q  <= onehot_err_d;
            read_data_q   <= read_data_d;
        end
    end

    assign bus.ch_req      = ch_req_q;
    assign bus.ch_sel      = ch_sel_q;
    assign bus.read_data   = read_data_q;
    assign bus.snap_valid  = snap_valid_q;
    assign bus.cur_ch      = cur_ch_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.onehot_err  = onehot_err_q;
    assign fsm_state       = state_q;
endmodule

// File: tb/tb_channel_snapshot_fetch.sv
// ----------------------------------------------------------------------------
// tb_channel_snapshot_fetch
// Directed bench for channel_snapshot_fetch: reset, basic fetch and byte
// sweep, all-channel sweep, timeout, retarget, illegal selects and reset
// during a fetch. Read-back bytes go through an expected queue.
// ----------------------------------------------------------------------------
module tb_channel_snapshot_fetch;
    logic sclk;
    logic rstn;
    logic fsm_state;

    channel_snapshot_fetch_if #(.N_CH(8), .BYTES(7)) bus ();

    channel_snapshot_fetch #(
        .N_CH(8), .BYTES(7), .TIMEOUT_CYCLES(16)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock / reset
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counters, scoreboard and reference model
    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_q[$];
    logic [55:0] model_snap  = '0;
    logic        model_valid = 1'b0;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int sel);
        logic [63:0] ext;
        ext = {8'h00, model_snap};
        if (!model_valid || sel > 6) return 8'h00;
        return ext[8*sel +: 8];
    endfunction

    // Drive select_reg, queue the model byte, compare one cycle later.
    task automatic read_check(input int sel);
        logic [7:0] e;
        bus.select_reg = sel[2:0];
        exp_q.push_back(model_byte(sel));
        tick();
        e = exp_q.pop_front();
        check($sformatf("read_data sel%0d", sel), {56'h0, bus.read_data}, {56'h0, e});
    endtask

    // One-cycle ack pulse carrying data.
    task automatic ack_pulse(input logic [55:0] data);
        bus.ch_ack  = 1'b1;
        bus.ch_data = data;
        tick();
        bus.ch_ack  = 1'b0;
        bus.ch_data = '0;
    endtask

    function automatic logic [55:0] chan_pattern(input int c);
        logic [55:0] p;
        for (int b = 0; b < 7; b++) p[8*b +: 8] = 8'((c << 4) | (b + 1));
        return p;
    endfunction

    initial begin
        logic [55:0] pat;
        rstn             = 1'b0;
        bus.load_cnt_ser = '0;
        bus.select_reg   = '0;
        bus.ch_ack       = 1'b0;
        bus.ch_data      = '0;
        tick();
        tick();
        check("rst ch_req", {63'h0, bus.ch_req}, 64'h0);
        check("rst ch_sel", {61'h0, bus.ch_sel}, 64'h0);
        check("rst read_data", {56'h0, bus.read_data}, 64'h0);
        check("rst snap_valid", {63'h0, bus.snap_valid}, 64'h0);
        check("rst cur_ch", {61'h0, bus.cur_ch}, 64'h0);
        check("rst timeout_err", {63'h0, bus.timeout_err}, 64'h0);
        check("rst onehot_err", {63'h0, bus.onehot_err}, 64'h0);
        check("rst state", {63'h0, fsm_state}, 64'h0);
        rstn = 1'b1;
        tick();

        // Basic fetch from channel 2
        bus.load_cnt_ser = 8'b0000_0100;
        tick();
        check("basic ch_req", {63'h0, bus.ch_req}, 64'h1);
        check("basic ch_sel", {61'h0, bus.ch_sel}, 64'h2);
        check("basic state", {63'h0, fsm_state}, 64'h1);
        tick();
        tick();
        ack_pulse(56'h66_55_44_33_22_11_00);
        model_snap  = 56'h66_55_44_33_22_11_00;
        model_valid = 1'b1;
        check("basic snap_valid", {63'h0, bus.snap_valid}, 64'h1);
        check("basic cur_ch", {61'h0, bus.cur_ch}, 64'h2);
        check("basic ch_req drop", {63'h0, bus.ch_req}, 64'h0);
        for (int s = 0; s < 8; s++) read_check(s);

        // Sweep all channels
        for (int c = 0; c < 8; c++) begin
            bus.load_cnt_ser = 8'(1 << c);
            tick();
            model_valid = 1'b0;
            check($sformatf("sweep ch_req c%0d", c), {63'h0, bus.ch_req}, 64'h1);
            check($sformatf("sweep ch_sel c%0d", c), {61'h0, bus.ch_sel}, 64'(c));
            tick();
            pat = chan_pattern(c);
            ack_pulse(pat);
            model_snap  = pat;
            model_valid = 1'b1;
            check($sformatf("sweep cur_ch c%0d", c), {61'h0, bus.cur_ch}, 64'(c));
            check($sformatf("sweep valid c%0d", c), {63'h0, bus.snap_valid}, 64'h1);
            for (int s = 0; s < 7; s++) read_check(s);
        end

        // Timeout on channel 4
        bus.load_cnt_ser = 8'b0001_0000;
        tick();
        model_valid = 1'b0;
        check("to ch_req first", {63'h0, bus.ch_req}, 64'h1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("to ch_req hold %0d", i), {63'h0, bus.ch_req}, 64'h1);
        end
        tick();
        model_snap = '0;
        check("to ch_req drop", {63'h0, bus.ch_req}, 64'h0);
        check("to timeout_err", {63'h0, bus.timeout_err}, 64'h1);
        check("to snap_valid", {63'h0, bus.snap_valid}, 64'h0);
        read_check(0);
        read_check(3);

        // Recovery fetch clears timeout_err
        bus.load_cnt_ser = 8'b0000_1000;
        tick();
        tick();
        pat = 56'hA6_A5_A4_A3_A2_A1_A0;
        ack_pulse(pat);
        model_snap  = pat;
        model_valid = 1'b1;
        check("rec timeout_err", {63'h0, bus.timeout_err}, 64'h0);
        check("rec cur_ch", {61'h0, bus.cur_ch}, 64'h3);
        read_check(6);

        // Retarget ch1 -> ch7 with a coincident ack
        bus.load_cnt_ser = 8'b0000_0010;
        tick();
        model_valid = 1'b0;
        check("rt ch_sel1", {61'h0, bus.ch_sel}, 64'h1);
        tick();
        bus.load_cnt_ser = 8'b1000_0000;
        ack_pulse(56'hBA_D0_BA_D0_BA_D0_BA);
        check("rt ch_req gap", {63'h0, bus.ch_req}, 64'h0);
        check("rt snap_valid", {63'h0, bus.snap_valid}, 64'h0);
        tick();
        check("rt ch_req again", {63'h0, bus.ch_req}, 64'h1);
        check("rt ch_sel7", {61'h0, bus.ch_sel}, 64'h7);
        pat = 56'h77_76_75_74_73_72_71;
        ack_pulse(pat);
        model_snap  = pat;
        model_valid = 1'b1;
        check("rt cur_ch", {61'h0, bus.cur_ch}, 64'h7);
        check("rt snap_valid after", {63'h0, bus.snap_valid}, 64'h1);
        read_check(0);

        // Multi-hot select and all-zero select
        bus.load_cnt_ser = 8'b0000_0011;
        tick();
        check("mh onehot_err", {63'h0, bus.onehot_err}, 64'h1);
        check("mh ch_req", {63'h0, bus.ch_req}, 64'h0);
        check("mh snap_valid", {63'h0, bus.snap_valid}, 64'h1);
        read_check(5);
        bus.load_cnt_ser = 8'b0000_0000;
        tick();
        check("zero snap_valid", {63'h0, bus.snap_valid}, 64'h1);
        check("zero onehot_err sticky", {63'h0, bus.onehot_err}, 64'h1);
        read_check(2);

        // Ack while idle is ignored
        ack_pulse(56'hDE_AD_DE_AD_DE_AD_DE);
        check("idle ack cur_ch", {61'h0, bus.cur_ch}, 64'h7);
        read_check(1);

        // Reset in the middle of a fetch
        bus.load_cnt_ser = 8'b0000_0100;
        tick();
        check("mid ch_req", {63'h0, bus.ch_req}, 64'h1);
        #2;
        rstn = 1'b0;
        #1;
        model_valid = 1'b0;
        model_snap  = '0;
        check("arst ch_req", {63'h0, bus.ch_req}, 64'h0);
        check("arst ch_sel", {61'h0, bus.ch_sel}, 64'h0);
        check("arst snap_valid", {63'h0, bus.snap_valid}, 64'h0);
        check("arst cur_ch", {61'h0, bus.cur_ch}, 64'h0);
        check("arst read_data", {56'h0, bus.read_data}, 64'h0);
        check("arst onehot_err", {63'h0, bus.onehot_err}, 64'h0);
        bus.ch_ack       = 1'b1;
        bus.ch_data      = 56'h12_34_56_78_9A_BC_DE;
        bus.load_cnt_ser = '0;
        tick();
        rstn = 1'b1;
        tick();
        bus.ch_ack  = 1'b0;
        bus.ch_data = '0;
        check("post rst snap_valid", {63'h0, bus.snap_valid}, 64'h0);
        check("post rst ch_req", {63'h0, bus.ch_req}, 64'h0);
        check("post rst state", {63'h0, fsm_state}, 64'h0);
        read_check(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
